// File: rtl/dmem_responder_if.sv
// Data-memory access bus between the core's load/store stage and the responder.
//
// Handshake rules, both channels: a transfer happens on a rising clk edge where
// valid and ready are both 1. Once valid is raised, the sender holds valid and
// its payload stable until that edge. The receiver may raise or drop ready at any
// time, and ready never depends combinationally on valid.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder. It takes one load or store at a time, commits it
// LATENCY cycles after acceptance and holds the response until the core takes it.
// Stores honour byte enables. Misaligned or out-of-range accesses return an error
// and do not touch memory.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus,
  output logic [1:0]      state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            commit;

  logic            lat_we;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_be;

  logic            acc_we;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;
  logic            acc_err;
  logic [AW-1:0]   acc_idx;

  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            handshake;

  assign accept         = bus.req_valid && (state == IDLE);
  assign handshake      = (state == RESP) && bus.resp_ready;
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign state_dbg      = state;

  // Access fields: live request inputs when committing on the accept edge (LATENCY==1), else the latched copy
  always_comb begin
    if (state == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_be    = bus.req_be;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
    end
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
  assign acc_idx = acc_addr[AW+1:2];

  // Next-state logic; commit marks the edge that enters RESP
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, countdown and latched request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_be    <= bus.req_be;
      end
    end
  end

  // Response payload: captured at commit, held through RESP, cleared on handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else if (commit) begin
      bus.resp_err   <= acc_err;
      bus.resp_rdata <= (acc_err || acc_we) ? 32'h0 : mem[acc_idx];
    end else if (handshake) begin
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end
  end

  // Byte-lane store into the array; contents survive reset
  always_ff @(posedge clk) begin
    if (commit && rst && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. Three instances (LATENCY 2, 1, 4) share the clock and
// reset. Each instance has its own bus and a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int NDUT  = 3;
  localparam int TMO   = 50;

  int lat_of [NDUT] = '{2, 1, 4};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid  [NDUT];
  logic        req_we     [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic [3:0]  req_be     [NDUT];
  logic        resp_ready [NDUT];
  logic        req_ready_o  [NDUT];
  logic        resp_valid_o [NDUT];
  logic [31:0] resp_rdata_o [NDUT];
  logic        resp_err_o   [NDUT];
  logic [1:0]  st [NDUT];

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();
  dmem_responder_if bus2 ();

  assign bus0.req_valid = req_valid[0];  assign bus1.req_valid = req_valid[1];  assign bus2.req_valid = req_valid[2];
  assign bus0.req_we    = req_we[0];     assign bus1.req_we    = req_we[1];     assign bus2.req_we    = req_we[2];
  assign bus0.req_addr  = req_addr[0];   assign bus1.req_addr  = req_addr[1];   assign bus2.req_addr  = req_addr[2];
  assign bus0.req_wdata = req_wdata[0];  assign bus1.req_wdata = req_wdata[1];  assign bus2.req_wdata = req_wdata[2];
  assign bus0.req_be    = req_be[0];     assign bus1.req_be    = req_be[1];     assign bus2.req_be    = req_be[2];
  assign bus0.resp_ready = resp_ready[0]; assign bus1.resp_ready = resp_ready[1]; assign bus2.resp_ready = resp_ready[2];
  assign req_ready_o[0]  = bus0.req_ready;  assign req_ready_o[1]  = bus1.req_ready;  assign req_ready_o[2]  = bus2.req_ready;
  assign resp_valid_o[0] = bus0.resp_valid; assign resp_valid_o[1] = bus1.resp_valid; assign resp_valid_o[2] = bus2.resp_valid;
  assign resp_rdata_o[0] = bus0.resp_rdata; assign resp_rdata_o[1] = bus1.resp_rdata; assign resp_rdata_o[2] = bus2.resp_rdata;
  assign resp_err_o[0]   = bus0.resp_err;   assign resp_err_o[1]   = bus1.resp_err;   assign resp_err_o[2]   = bus2.resp_err;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (.clk(clk), .rst(rst), .bus(bus0.slave), .state_dbg(st[0]));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (.clk(clk), .rst(rst), .bus(bus1.slave), .state_dbg(st[1]));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_lat4 (.clk(clk), .rst(rst), .bus(bus2.slave), .state_dbg(st[2]));

  int total = 0;
  int bad   = 0;

  // Reference memory per instance: plain word arrays
  logic [31:0] mdl [NDUT][DEPTH];

  // Expected {err, rdata} of one access; stores update the model word lane by lane
  function automatic logic [32:0] model_access(input int k, input logic we, input logic [31:0] addr,
                                                input logic [31:0] wd, input logic [3:0] be);
    int w;
    if ((addr % 4) != 0 || (addr / 4) >= DEPTH) return {1'b1, 32'h0};
    w = int'(addr / 4);
    if (we) begin
      for (int i = 0; i < 4; i++) if (be[i]) mdl[k][w][8*i +: 8] = wd[8*i +: 8];
      return {1'b0, 32'h0};
    end
    return {1'b0, mdl[k][w]};
  endfunction

  // Mostly legal word addresses, with some misaligned and out-of-range ones
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      1: return 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) * 4;
      2: return ($urandom | 32'h8000_0000) & ~32'h3;
      default: return 32'($urandom_range(0, DEPTH - 1)) * 4;
    endcase
  endfunction

  // Driver: present a request and return #1 after the edge that accepts it
  task automatic send_req(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, output bit to);
    int n = 0;
    req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wd; req_be[k] = be; req_valid[k] = 1'b1;
    while (!req_ready_o[k] && n < TMO) begin
      @(posedge clk); #1; n++;
    end
    to = !req_ready_o[k];
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  // Driver: count edges from the acceptance edge until resp_valid is seen
  task automatic wait_resp(input int k, output int cyc, output bit to);
    cyc = 1;
    while (!resp_valid_o[k] && cyc < TMO) begin
      @(posedge clk); #1; cyc++;
    end
    to = !resp_valid_o[k];
  endtask

  // Driver: take the pending response with a one-cycle resp_ready pulse
  task automatic take_resp(input int k, output logic [31:0] rd, output logic er);
    rd = resp_rdata_o[k];
    er = resp_err_o[k];
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
  endtask

  task automatic do_op(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er, output int cyc, output bit to);
    bit t1, t2;
    send_req(k, we, addr, wd, be, t1);
    wait_resp(k, cyc, t2);
    if (!t2) take_resp(k, rd, er);
    else begin rd = 'x; er = 1'bx; end
    to = t1 | t2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      total++; if (resp_valid_o[k] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", k, resp_valid_o[k]); end
      total++; if (resp_rdata_o[k] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, resp_rdata_o[k]); end
      total++; if (resp_err_o[k] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", k, resp_err_o[k]); end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NDUT; k++) begin
      total++; if (req_ready_o[k] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 1", k, req_ready_o[k]); end
    end
  endtask

  // Give every word a known random value so later loads are meaningful
  task automatic fill_memories();
    logic [31:0] rd, wd; logic er; logic [32:0] e; int cyc; bit to;
    for (int k = 0; k < NDUT; k++) begin
      for (int w = 0; w < DEPTH; w++) begin
        wd = $urandom;
        e = model_access(k, 1'b1, 32'(w) * 4, wd, 4'hF);
        do_op(k, 1'b1, 32'(w) * 4, wd, 4'hF, rd, er, cyc, to);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; logic [32:0] e; int cyc; bit to;
    e = model_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, cyc, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL store_timeout: got %b want 0", to); end
    total++; if (cyc !== 2) begin bad++; $display("FAIL store_latency: got %0d want 2", cyc); end
    total++; if ({er, rd} !== {1'b0, 32'h0}) begin bad++; $display("FAIL store_resp: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    e = model_access(0, 1'b0, 32'h10, 32'h0, 4'h0);
    do_op(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc, to);
    total++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL load_after_store: got err=%b rdata=%h want err=0 rdata=deadbeef", er, rd); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; logic [32:0] e; int cyc; bit to;
    e = model_access(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    do_op(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, cyc, to);
    e = model_access(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    do_op(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, cyc, to);
    total++; if ({er, rd} !== e) begin bad++; $display("FAIL be_store_resp: got %h want %h", {er, rd}, e); end
    e = model_access(0, 1'b0, 32'h20, 32'h0, 4'h0);
    do_op(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc, to);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL be_load: got %h want 11bb33dd", rd); end
    e = model_access(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    do_op(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, cyc, to);
    total++; if (to !== 1'b0 || er !== 1'b0) begin bad++; $display("FAIL be_zero_resp: got to=%b err=%b want 0 0", to, er); end
    do_op(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc, to);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL be_zero_noop: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, a; logic er; logic [32:0] e; int cyc; bit t1, t2;
    a = 32'($urandom_range(0, DEPTH - 1)) * 4;
    e = model_access(0, 1'b0, a, 32'h0, 4'h0);
    send_req(0, 1'b0, a, 32'h0, 4'h0, t1);
    wait_resp(0, cyc, t2);
    total++; if ((t1 | t2) !== 1'b0) begin bad++; $display("FAIL bp_timeout: got %b want 0", t1 | t2); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (resp_valid_o[0] !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, resp_valid_o[0]); end
      total++; if ({resp_err_o[0], resp_rdata_o[0]} !== e) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, {resp_err_o[0], resp_rdata_o[0]}, e); end
      total++; if (req_ready_o[0] !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, req_ready_o[0]); end
    end
    take_resp(0, rd, er);
    total++; if ({er, rd} !== e) begin bad++; $display("FAIL bp_take: got %h want %h", {er, rd}, e); end
    total++; if (req_ready_o[0] !== 1'b1 || resp_valid_o[0] !== 1'b0) begin bad++; $display("FAIL bp_release: got ready=%b valid=%b want 1 0", req_ready_o[0], resp_valid_o[0]); end
    total++; if ({resp_err_o[0], resp_rdata_o[0]} !== 33'h0) begin bad++; $display("FAIL bp_clear: got %h want 0", {resp_err_o[0], resp_rdata_o[0]}); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; logic [32:0] e; int cyc; bit to;
    e = model_access(0, 1'b0, 32'h22, 32'h0, 4'h0);
    do_op(0, 1'b0, 32'h22, 32'h0, 4'h0, rd, er, cyc, to);
    total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL err_misaligned: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    e = model_access(0, 1'b1, 32'(DEPTH * 4), 32'hBAD0BAD0, 4'hF);
    do_op(0, 1'b1, 32'(DEPTH * 4), 32'hBAD0BAD0, 4'hF, rd, er, cyc, to);
    total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL err_range: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    e = model_access(0, 1'b0, 32'h0, 32'h0, 4'h0);
    do_op(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, cyc, to);
    total++; if ({er, rd} !== e) begin bad++; $display("FAIL err_no_corrupt: got %h want %h", {er, rd}, e); end
  endtask

  task automatic test_latency_sweep();
    logic [31:0] rd, a, wd; logic er, we; logic [3:0] be; logic [32:0] e; int cyc; bit to;
    logic [32:0] exp_q [$];
    int pushed, last, n;
    for (int k = 0; k < NDUT; k++) begin
      // Isolated random accesses: latency and data
      for (int i = 0; i < 6; i++) begin
        we = 1'($urandom_range(0, 1)); a = rand_addr(); wd = $urandom; be = 4'($urandom_range(0, 15));
        e = model_access(k, we, a, wd, be);
        do_op(k, we, a, wd, be, rd, er, cyc, to);
        total++; if (cyc !== lat_of[k] || to !== 1'b0) begin bad++; $display("FAIL lat[%0d]: got %0d to=%b want %0d", k, cyc, to, lat_of[k]); end
        total++; if ({er, rd} !== e) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h addr=%h we=%b", k, {er, rd}, e, a, we); end
      end
      // Back-to-back with request and response always ready
      resp_ready[k] = 1'b1;
      pushed = 0; last = 0; n = 0;
      while (!(pushed == 8 && exp_q.size() == 0) && n < 400) begin
        if (resp_valid_o[k]) begin
          total++;
          if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_extra[%0d]: got unexpected response want none", k); end
          else begin
            e = exp_q.pop_front();
            if ({resp_err_o[k], resp_rdata_o[k]} !== e) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, {resp_err_o[k], resp_rdata_o[k]}, e); end
          end
        end
        if (req_ready_o[k]) begin
          if (pushed < 8) begin
            req_we[k] = 1'($urandom_range(0, 1)); req_addr[k] = rand_addr();
            req_wdata[k] = $urandom; req_be[k] = 4'($urandom_range(0, 15)); req_valid[k] = 1'b1;
            exp_q.push_back(model_access(k, req_we[k], req_addr[k], req_wdata[k], req_be[k]));
            if (pushed > 0) begin
              total++; if (n - last !== lat_of[k] + 1) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, n - last, lat_of[k] + 1); end
            end
            last = n; pushed++;
          end else begin
            req_valid[k] = 1'b0;
          end
        end
        @(posedge clk); #1; n++;
      end
      req_valid[k] = 1'b0;
      resp_ready[k] = 1'b0;
      total++; if (n >= 400) begin bad++; $display("FAIL b2b_timeout[%0d]: got %0d cycles want < 400", k, n); end
      exp_q.delete();
    end
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd; logic er; logic [32:0] e; int cyc; bit to;
    e = model_access(0, 1'b1, 32'h30, 32'h0, 4'hF);
    do_op(0, 1'b1, 32'h30, 32'h0, 4'hF, rd, er, cyc, to);
    // Store accepted, then reset while it is still in flight: never committed
    send_req(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, to);
    rst = 1'b0; #1;
    total++; if ({resp_valid_o[0], resp_err_o[0], resp_rdata_o[0]} !== 34'h0) begin bad++; $display("FAIL rst_busy_outputs: got %h want 0", {resp_valid_o[0], resp_err_o[0], resp_rdata_o[0]}); end
    total++; if (st[0] !== 2'd0) begin bad++; $display("FAIL rst_busy_state: got %0d want 0", st[0]); end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    e = model_access(0, 1'b0, 32'h30, 32'h0, 4'h0);
    do_op(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, cyc, to);
    total++; if ({er, rd} !== {1'b0, 32'h0}) begin bad++; $display("FAIL rst_busy_discard: got %h want 0", {er, rd}); end
    // Reset while the response is pending: the store already landed
    e = model_access(0, 1'b1, 32'h34, 32'h5A5A1234, 4'hF);
    send_req(0, 1'b1, 32'h34, 32'h5A5A1234, 4'hF, to);
    wait_resp(0, cyc, to);
    rst = 1'b0; #1;
    total++; if (resp_valid_o[0] !== 1'b0) begin bad++; $display("FAIL rst_resp_drop: got %b want 0", resp_valid_o[0]); end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    e = model_access(0, 1'b0, 32'h34, 32'h0, 4'h0);
    do_op(0, 1'b0, 32'h34, 32'h0, 4'h0, rd, er, cyc, to);
    total++; if ({er, rd} !== {1'b0, 32'h5A5A1234}) begin bad++; $display("FAIL rst_resp_kept: got %h want 05a5a1234", {er, rd}); end
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_be[k] = '0; resp_ready[k] = 1'b0;
    end
    test_reset();
    fill_memories();
    test_store_load();
    test_byte_enable();
    test_backpressure();
    test_errors();
    test_latency_sweep();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
